// File: rtl/axi4_mem_pkg.sv
// axi4_mem_pkg: shared response/burst codes, channel states and address stepping
package axi4_mem_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == INCR) ? addr + 32'd8 : addr;
  endfunction
endpackage

// File: rtl/axi4_mem_bank.sv
// axi4_mem_bank: 64-bit word memory with byte-enabled write and registered read
module axi4_mem_bank #(
  parameter int WORDS = 256,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [WORDS];
  // write selected lanes; a same-cycle read of that word returns the old contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 memory slave with independent write and read channel engines
module axi4_mem_slave import axi4_mem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 8);

  function automatic logic in_rng(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IW-1:0] widx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 3);
  endfunction

  wstate_e     wstate;
  logic [31:0] waddr;
  logic [7:0]  wlen, wcnt;
  logic [1:0]  wburst;
  logic        w_slv, w_dec;
  rstate_e     rstate;
  logic [31:0] raddr;
  logic [7:0]  rlen, rcnt;
  logic [1:0]  rburst;
  logic        r_slv, r_zero;
  logic [63:0] q;

  logic unused;
  assign unused = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  assign awready = wstate == W_IDLE;
  assign wready  = wstate == W_DATA;
  assign bvalid  = wstate == W_RESP;
  assign arready = rstate == R_IDLE;

  logic w_end, w_bad, w_in, we;
  assign w_end = wcnt == wlen;
  assign w_bad = wlast != w_end;
  assign w_in  = in_rng(waddr);
  assign we    = wvalid & wready & w_in & ~w_slv & ~w_bad;

  logic        ar_hs, r_end, slv_n, rd_en;
  logic [31:0] rd_a;
  logic [1:0]  resp_n;
  assign ar_hs  = arvalid & arready;
  assign r_end  = rcnt == rlen;
  assign rd_a   = ar_hs ? araddr : next_addr(raddr, rburst);
  assign slv_n  = ar_hs ? (arburst == WRAP || arsize != 3'd3) : r_slv;
  assign rd_en  = (ar_hs | (rvalid & rready & ~r_end)) & ~slv_n & in_rng(rd_a);
  assign resp_n = slv_n ? SLVERR : in_rng(rd_a) ? OKAY : DECERR;
  assign rdata  = r_zero ? '0 : q;

  axi4_mem_bank #(.WORDS(MEM_WORDS)) u_bank (
    .clk(clk), .we(we), .waddr(widx(waddr)), .wdata(wdata), .wstrb(wstrb),
    .re(rd_en), .raddr(widx(rd_a)), .rdata(q)
  );

  // write engine: latch AW, stream beats, accumulate error status into one B response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= W_IDLE;
      waddr  <= '0;
      wlen   <= '0;
      wcnt   <= '0;
      wburst <= '0;
      w_slv  <= 1'b0;
      w_dec  <= 1'b0;
      bresp  <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: if (awvalid) begin
          waddr  <= awaddr;
          wlen   <= awlen;
          wburst <= awburst;
          wcnt   <= '0;
          w_slv  <= awburst == WRAP || awsize != 3'd3;
          w_dec  <= 1'b0;
          wstate <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          waddr <= next_addr(waddr, wburst);
          wcnt  <= wcnt + 8'd1;
          w_slv <= w_slv | w_bad;
          w_dec <= w_dec | ~w_in;
          if (w_end) begin
            wstate <= W_RESP;
            bresp  <= (w_slv | w_bad) ? SLVERR : (w_dec | ~w_in) ? DECERR : OKAY;
          end
        end
        W_RESP: if (bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // read engine: each accepted beat preloads the next so rdata is ready the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      raddr  <= '0;
      rlen   <= '0;
      rcnt   <= '0;
      rburst <= '0;
      r_slv  <= 1'b0;
      r_zero <= 1'b1;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rresp  <= OKAY;
    end else if (rstate == R_IDLE) begin
      if (arvalid) begin
        raddr  <= araddr;
        rlen   <= arlen;
        rburst <= arburst;
        rcnt   <= '0;
        r_slv  <= slv_n;
        r_zero <= ~rd_en;
        rvalid <= 1'b1;
        rlast  <= arlen == 8'd0;
        rresp  <= resp_n;
        rstate <= R_DATA;
      end
    end else if (rready) begin
      if (r_end) begin
        rstate <= R_IDLE;
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end else begin
        raddr  <= rd_a;
        rcnt   <= rcnt + 8'd1;
        rlast  <= rcnt + 8'd1 == rlen;
        r_zero <= ~rd_en;
        rresp  <= resp_n;
      end
    end
  end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: random and directed bursts checked against a byte-level memory model
module tb_axi4_mem_slave;
  import axi4_mem_pkg::*;
  localparam logic [31:0] BASE = 32'h0;
  localparam int WORDS = 256;

  logic clk, rst_n;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] awcache, arcache;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;

  axi4_mem_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] model [WORDS];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a - BASE) < WORDS * 8;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz,
                          input logic [1:0] bu, input int bstall, input int bad);
    logic [31:0] ad;
    logic slv, dec;
    logic [1:0] exp;
    ad = a;
    slv = (bu == WRAP) || (sz != 3'd3);
    dec = 1'b0;
    @(negedge clk);
    check("awready", awready, 1);
    awaddr = a; awlen = 8'(len); awsize = sz; awburst = bu; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) != (i == bad); wvalid = 1'b1;
      @(negedge clk);
      check("wready", wready, 1);
      if (i == bad) slv = 1'b1;
      if (!in_rng(ad)) dec = 1'b1;
      else if (!slv)
        for (int b = 0; b < 8; b++) if (ws[i][b]) model[idx(ad)][b*8 +: 8] = wd[i][b*8 +: 8];
      @(posedge clk); #1;
      if (bu == INCR) ad = ad + 32'd8;
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp = slv ? SLVERR : dec ? DECERR : OKAY;
    for (int c = 0; c < bstall; c++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, exp);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, exp);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("bvalid_clr", bvalid, 0);
    check("awready_back", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input int sbeat, input int sn);
    logic [31:0] ad;
    logic slv;
    logic [63:0] ed;
    logic [1:0] er;
    ad = a;
    slv = (bu == WRAP) || (sz != 3'd3);
    @(negedge clk);
    check("arready", arready, 1);
    araddr = a; arlen = 8'(len); arsize = sz; arburst = bu; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ed = (slv || !in_rng(ad)) ? 64'h0 : model[idx(ad)];
      er = slv ? SLVERR : in_rng(ad) ? OKAY : DECERR;
      if (i == sbeat)
        for (int c = 0; c < sn; c++) begin
          @(negedge clk);
          check("rvalid_hold", rvalid, 1);
          check("rdata_hold", rdata, ed);
          check("rresp_hold", rresp, er);
          check("rlast_hold", rlast, i == len);
          @(posedge clk); #1;
        end
      rready = 1'b1;
      @(negedge clk);
      check("rvalid", rvalid, 1);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      check("rlast", rlast, i == len);
      @(posedge clk); #1 rready = 1'b0;
      if (bu == INCR) ad = ad + 32'd8;
    end
    @(negedge clk);
    check("rvalid_clr", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    {awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);

    for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(32'h0, 255, 3'd3, INCR, 0, -1);

    for (int i = 0; i < 4; i++) begin wd[i] = {16{4'(i + 1)}}; ws[i] = 8'hFF; end
    do_write(32'h10, 3, 3'd3, INCR, 3, -1);
    do_read(32'h10, 3, 3'd3, INCR, -1, 0);

    wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'hFF;
    do_write(32'h0, 0, 3'd3, INCR, 0, -1);
    wd[0] = 64'hAABBCCDD_EEFF0011; ws[0] = 8'h0F;
    do_write(32'h0, 0, 3'd3, INCR, 0, -1);
    do_read(32'h0, 0, 3'd3, INCR, -1, 0);

    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(32'h7F8, 1, 3'd3, INCR, 0, -1);
    do_read(32'h7F8, 1, 3'd3, INCR, -1, 0);
    do_read(32'h800, 0, 3'd3, INCR, -1, 0);

    do_read(32'h20, 1, 3'd3, WRAP, -1, 0);
    do_write(32'h40, 1, 3'd2, INCR, 0, -1);
    do_read(32'h40, 1, 3'd3, INCR, -1, 0);
    do_write(32'h80, 1, 3'd3, INCR, 0, 0);
    do_read(32'h80, 1, 3'd3, INCR, -1, 0);

    do_read(32'h100, 7, 3'd3, INCR, 3, 5);
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
    do_write(32'h200, 2, 3'd3, FIXED, 1, -1);
    do_read(32'h200, 2, 3'd3, FIXED, 0, 2);

    for (int t = 0; t < 8; t++) begin
      int len;
      logic [31:0] a;
      len = int'($urandom_range(0, 7));
      a = 32'($urandom_range(240, 255)) << 3;
      for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      do_write(a, len, 3'd3, INCR, int'($urandom_range(0, 2)), -1);
      do_read(a, len, 3'd3, INCR, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
    end

    @(negedge clk);
    awaddr = 32'h300; awlen = 8'd7; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    model[idx(32'h300)] = wdata;
    @(posedge clk); #1 wdata = {$urandom, $urandom};
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("mid_rst_wready", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_arready", arready, 1);
    wvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(32'h400, 1, 3'd3, INCR, 0, -1);
    do_read(32'h300, 1, 3'd3, INCR, -1, 0);
    do_read(32'h400, 1, 3'd3, INCR, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
